// File: rtl/timer_pkg.sv
// Shared types and constants for the microwave timer controller.
// Holds the FSM encoding, digit limits and the default tick rate.
package timer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ENTRY = 3'd1,
      ST_LOAD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_PAUSE = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [3:0]  SEC_TENS_MAX    = 4'd5;
   localparam logic [3:0]  DIGIT_MAX       = 4'd9;
   localparam int unsigned CLK_PER_SEC_DEF = 100;

   // A key shifts units into tens, so the current units digit must be a legal tens digit.
   function automatic logic key_accepted(input logic [3:0] key, input logic [3:0] units);
      return (key <= DIGIT_MAX) && (units <= SEC_TENS_MAX);
   endfunction

endpackage

// File: rtl/microwave_timer_ctrl_if.sv
// Panel, counter-chain and status signals of the microwave timer controller.
// slave = controller side, master = panel/counter-chain side.
interface microwave_timer_ctrl_if;
   logic [3:0] key;
   logic       key_valid;
   logic       start;
   logic       stop_clear;
   logic       door_closed;
   logic       cnt_zero;
   logic [3:0] data_min;
   logic [3:0] data_tens;
   logic [3:0] data_units;
   logic       cnt_loadn;
   logic       cnt_en;
   logic       cnt_clrn;
   logic       magnetron;
   logic       done;
   logic [2:0] state;

   modport slave (
      input  key, key_valid, start, stop_clear, door_closed, cnt_zero,
      output data_min, data_tens, data_units, cnt_loadn, cnt_en, cnt_clrn,
             magnetron, done, state
   );

   modport master (
      output key, key_valid, start, stop_clear, door_closed, cnt_zero,
      input  data_min, data_tens, data_units, cnt_loadn, cnt_en, cnt_clrn,
             magnetron, done, state
   );
endinterface

// File: rtl/microwave_timer_ctrl_tick_prescaler.sv
// Mod-DIV cycle counter with sync clear and hold; tc_o flags the last count of a second.
// Advances only while inc_i is high; tc_o is combinational from the count register.
module tick_prescaler #(
   parameter int unsigned DIV = 100
) (
   input  logic clk,
   input  logic clrn,
   input  logic clr_i,
   input  logic inc_i,
   output logic tc_o
);
   localparam int unsigned W    = $clog2(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt_q;

   assign tc_o = (cnt_q == LAST);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i) begin
         cnt_q <= tc_o ? '0 : cnt_q + W'(1);
      end
   end
endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave timer FSM: keypad MM:SS entry, counter-chain load/enable/clear, 1 Hz tick, magnetron gate.
// All outputs registered and reflect the state entered on the same edge.
module microwave_timer_ctrl
   import timer_pkg::*;
#(
   parameter int unsigned CLK_PER_SEC = CLK_PER_SEC_DEF
) (
   input  logic                   clk,
   input  logic                   clrn,
   microwave_timer_ctrl_if.slave  bus
);
   state_t     state_q;
   logic [3:0] min_q, tens_q, units_q;
   logic       cnt_loadn_q, cnt_en_q, cnt_clrn_q, magnetron_q, done_q;

   logic presc_clr, presc_inc, presc_tc;
   logic preset_nz, key_ok, load_go;

   assign preset_nz = |{min_q, tens_q, units_q};
   assign key_ok    = bus.key_valid && key_accepted(bus.key, units_q);
   assign load_go   = bus.start && bus.door_closed && preset_nz;

   // The prescaler only advances on cycles where RUN is held and the chain is still counting.
   assign presc_clr = (state_q == ST_LOAD);
   assign presc_inc = (state_q == ST_RUN) && bus.door_closed && !bus.stop_clear && !bus.cnt_zero;

   tick_prescaler #(.DIV(CLK_PER_SEC)) u_tick_prescaler (
      .clk   (clk),
      .clrn  (clrn),
      .clr_i (presc_clr),
      .inc_i (presc_inc),
      .tc_o  (presc_tc)
   );

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q     <= ST_IDLE;
         min_q       <= '0;
         tens_q      <= '0;
         units_q     <= '0;
         cnt_loadn_q <= 1'b1;
         cnt_en_q    <= 1'b0;
         cnt_clrn_q  <= 1'b1;
         magnetron_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         cnt_loadn_q <= 1'b1;
         cnt_en_q    <= 1'b0;
         cnt_clrn_q  <= 1'b1;
         magnetron_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            ST_IDLE, ST_ENTRY: begin
               if (load_go) begin
                  state_q     <= ST_LOAD;
                  cnt_loadn_q <= 1'b0;
               end else if (state_q == ST_ENTRY && bus.stop_clear) begin
                  state_q    <= ST_IDLE;
                  min_q      <= '0;
                  tens_q     <= '0;
                  units_q    <= '0;
                  cnt_clrn_q <= 1'b0;
               end else if (key_ok) begin
                  state_q <= ST_ENTRY;
                  min_q   <= tens_q;
                  tens_q  <= units_q;
                  units_q <= bus.key;
               end
            end
            ST_LOAD: begin
               state_q     <= ST_RUN;
               magnetron_q <= 1'b1;
            end
            ST_RUN: begin
               if (!bus.door_closed || bus.stop_clear) begin
                  state_q <= ST_PAUSE;
               end else if (bus.cnt_zero) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else begin
                  magnetron_q <= 1'b1;
                  cnt_en_q    <= presc_tc;
               end
            end
            ST_PAUSE: begin
               if (bus.stop_clear) begin
                  state_q    <= ST_IDLE;
                  min_q      <= '0;
                  tens_q     <= '0;
                  units_q    <= '0;
                  cnt_clrn_q <= 1'b0;
               end else if (bus.start && bus.door_closed) begin
                  state_q     <= ST_RUN;
                  magnetron_q <= 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.stop_clear || !bus.door_closed) begin
                  state_q    <= ST_IDLE;
                  min_q      <= '0;
                  tens_q     <= '0;
                  units_q    <= '0;
                  cnt_clrn_q <= 1'b0;
               end else begin
                  done_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               min_q   <= '0;
               tens_q  <= '0;
               units_q <= '0;
            end
         endcase
      end
   end

   assign bus.data_min   = min_q;
   assign bus.data_tens  = tens_q;
   assign bus.data_units = units_q;
   assign bus.cnt_loadn  = cnt_loadn_q;
   assign bus.cnt_en     = cnt_en_q;
   assign bus.cnt_clrn   = cnt_clrn_q;
   assign bus.magnetron  = magnetron_q;
   assign bus.done       = done_q;
   assign bus.state      = state_q;
endmodule
